// File: rtl/psram_xfer_engine.sv
// PSRAM pin-level transfer engine: CMD, ADDR, optional dummy, DATA.
// SPI mode 0 with single- or quad-line address/data.
`timescale 1ns/1ps
module psram_xfer_engine #(
    parameter int PSCR_WIDTH = 8,
    parameter int WAIT_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    input  logic [7:0]            cmd_i,
    input  logic [WAIT_WIDTH-1:0] wait_i,
    input  logic                  quad_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wr_i,
    input  logic [23:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  busy_o,
    output logic                  psram_sck_o,
    output logic                  psram_ce_o,
    output logic [3:0]            psram_io_en_o,
    input  logic [3:0]            psram_io_in_i,
    output logic [3:0]            psram_io_out_o
);

    // Counter must hold the longest phase: 32 single-line bits or the dummy count.
    localparam int CNT_W = (WAIT_WIDTH > 6) ? WAIT_WIDTH : 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_END
    } state_t;

    state_t state;
    state_t state_nx;

    logic [PSCR_WIDTH-1:0] div_cnt;
    logic [PSCR_WIDTH-1:0] pscr_q;
    logic [WAIT_WIDTH-1:0] wait_q;
    logic                  quad_q;
    logic                  wr_q;
    logic [23:0]           addr_q;
    logic [31:0]           wdata_q;
    logic                  sck_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [31:0]           sh_out;
    logic [31:0]           sh_in;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;

    logic tick;
    logic rise;
    logic fall;
    logic last;
    logic accept;
    logic ld_addr;
    logic ld_wait;
    logic ld_data;
    logic done;

    assign tick = (div_cnt == pscr_q);
    assign rise = tick && !sck_q;
    assign fall = tick && sck_q;
    assign last = (bit_cnt == '0);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        ld_addr  = 1'b0;
        ld_wait  = 1'b0;
        ld_data  = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    accept   = 1'b1;
                    state_nx = S_CMD;
                end
            end
            S_CMD: begin
                if (fall && last) begin
                    ld_addr  = 1'b1;
                    state_nx = S_ADDR;
                end
            end
            S_ADDR: begin
                if (fall && last) begin
                    if (!wr_q && wait_q != '0) begin
                        ld_wait  = 1'b1;
                        state_nx = S_WAIT;
                    end else begin
                        ld_data  = 1'b1;
                        state_nx = S_DATA;
                    end
                end
            end
            S_WAIT: begin
                if (fall && last) begin
                    ld_data  = 1'b1;
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (fall && last) begin
                    done     = 1'b1;
                    state_nx = S_END;
                end
            end
            S_END: begin
                if (fall) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            pscr_q      <= '0;
            wait_q      <= '0;
            quad_q      <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sck_q       <= 1'b0;
            bit_cnt     <= '0;
            sh_out      <= '0;
            sh_in       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state       <= state_nx;
            rsp_valid_q <= done;
            if (done) begin
                rsp_rdata_q <= wr_q ? 32'h0 : sh_in;
            end
            if (accept) begin
                pscr_q  <= pscr_i;
                wait_q  <= wait_i;
                quad_q  <= quad_i;
                wr_q    <= req_wr_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                div_cnt <= '0;
                sck_q   <= 1'b0;
                sh_out  <= {cmd_i, 24'h0};
                sh_in   <= '0;
                bit_cnt <= CNT_W'(7);
            end else if (state != S_IDLE) begin
                if (tick) begin
                    div_cnt <= '0;
                    sck_q   <= ~sck_q;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if (rise && state == S_DATA && !wr_q) begin
                    sh_in <= quad_q ? {sh_in[27:0], psram_io_in_i}
                                    : {sh_in[30:0], psram_io_in_i[1]};
                end
                if (fall && state != S_END && !done) begin
                    if (ld_addr) begin
                        sh_out  <= {addr_q, 8'h0};
                        bit_cnt <= quad_q ? CNT_W'(5) : CNT_W'(23);
                    end else if (ld_wait) begin
                        bit_cnt <= CNT_W'(wait_q) - CNT_W'(1);
                    end else if (ld_data) begin
                        sh_out  <= wdata_q;
                        bit_cnt <= quad_q ? CNT_W'(7) : CNT_W'(31);
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        if (state == S_CMD || !quad_q) begin
                            sh_out <= {sh_out[30:0], 1'b0};
                        end else begin
                            sh_out <= {sh_out[27:0], 4'h0};
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        psram_io_en_o = 4'b0000;
        unique case (state)
            S_CMD:  psram_io_en_o = 4'b0001;
            S_ADDR: psram_io_en_o = quad_q ? 4'b1111 : 4'b0001;
            S_DATA: begin
                if (wr_q) begin
                    psram_io_en_o = quad_q ? 4'b1111 : 4'b0001;
                end
            end
            default: psram_io_en_o = 4'b0000;
        endcase
    end

    always_comb begin
        psram_io_out_o = 4'b0000;
        if (state == S_CMD) begin
            psram_io_out_o = {3'b000, sh_out[31]};
        end else if (quad_q) begin
            psram_io_out_o = sh_out[31:28] & psram_io_en_o;
        end else begin
            psram_io_out_o = {3'b000, sh_out[31]} & psram_io_en_o;
        end
    end

    assign psram_sck_o = sck_q && state != S_END && state != S_IDLE;
    assign psram_ce_o  = (state == S_IDLE) || (state == S_END);
    assign req_ready_o = (state == S_IDLE);
    assign busy_o      = (state != S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_psram_xfer_engine.sv
// Bench for psram_xfer_engine: PSRAM pin model plus scoreboard.
// Expected transactions are queued on issue, checked on rsp_valid.
`timescale 1ns/1ps
module tb_psram_xfer_engine;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  pscr_i;
    logic [7:0]  cmd_i;
    logic [7:0]  wait_i;
    logic        quad_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wr_i;
    logic [23:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        busy_o;
    logic        psram_sck_o;
    logic        psram_ce_o;
    logic [3:0]  psram_io_en_o;
    logic [3:0]  psram_io_in_i;
    logic [3:0]  psram_io_out_o;

    psram_xfer_engine dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .pscr_i         (pscr_i),
        .cmd_i          (cmd_i),
        .wait_i         (wait_i),
        .quad_i         (quad_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_wr_i       (req_wr_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .busy_o         (busy_o),
        .psram_sck_o    (psram_sck_o),
        .psram_ce_o     (psram_ce_o),
        .psram_io_en_o  (psram_io_en_o),
        .psram_io_in_i  (psram_io_in_i),
        .psram_io_out_o (psram_io_out_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        quad;
        logic [7:0]  pscr;
        logic [7:0]  cmd;
        logic [7:0]  wt;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rises;
        int          per;
    } txn_t;

    txn_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic wr, input logic quad,
                                input logic [7:0] pscr,
                                input logic [7:0] cmd,
                                input logic [7:0] wt,
                                input logic [23:0] addr,
                                input logic [31:0] wdata,
                                input logic [31:0] rdata);
        txn_t t;
        t.wr    = wr;
        t.quad  = quad;
        t.pscr  = pscr;
        t.cmd   = cmd;
        t.wt    = wt;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = rdata;
        t.rises = 8 + (quad ? 6 : 24) + (wr ? 0 : int'(wt))
                + (quad ? 8 : 32);
        t.per   = 20 * (int'(pscr) + 1);
        return t;
    endfunction

    // PSRAM pin model: captures outgoing fields, drives read data.
    int          rises;
    logic [7:0]  cmd_cap;
    logic [23:0] addr_cap;
    logic [31:0] wd_cap;
    int          en_bad;
    time         t_last;
    int          per;

    always @(posedge psram_sck_o or negedge psram_ce_o) begin
        txn_t cur;
        int   an;
        int   wn;
        int   dn;
        int   k;
        if (!psram_sck_o) begin
            rises         = 0;
            cmd_cap       = '0;
            addr_cap      = '0;
            wd_cap        = '0;
            en_bad        = 0;
            t_last        = 0;
            per           = 0;
            psram_io_in_i = 4'h0;
        end else if (!psram_ce_o && sb.size() > 0) begin
            cur = sb[0];
            an  = cur.quad ? 6 : 24;
            wn  = cur.wr ? 0 : int'(cur.wt);
            dn  = cur.quad ? 8 : 32;
            if ((psram_io_out_o & ~psram_io_en_o) != 4'h0) en_bad++;
            if (rises < 8) begin
                cmd_cap = {cmd_cap[6:0], psram_io_out_o[0]};
                if (psram_io_en_o != 4'b0001) en_bad++;
            end else if (rises < 8 + an) begin
                addr_cap = cur.quad ? {addr_cap[19:0], psram_io_out_o}
                                    : {addr_cap[22:0], psram_io_out_o[0]};
                if (psram_io_en_o != (cur.quad ? 4'hf : 4'h1)) en_bad++;
            end else if (rises < 8 + an + wn) begin
                if (psram_io_en_o != 4'h0) en_bad++;
            end else if (cur.wr) begin
                wd_cap = cur.quad ? {wd_cap[27:0], psram_io_out_o}
                                  : {wd_cap[30:0], psram_io_out_o[0]};
                if (psram_io_en_o != (cur.quad ? 4'hf : 4'h1)) en_bad++;
            end else begin
                if (psram_io_en_o != 4'h0) en_bad++;
            end
            if (t_last != 0) per = int'($time - t_last);
            t_last = $time;
            rises++;
            k = rises - (8 + an + wn);
            psram_io_in_i = 4'h0;
            if (!cur.wr && k >= 0 && k < dn) begin
                if (cur.quad) psram_io_in_i = 4'((cur.rdata >> (28 - 4 * k)) & 32'hf);
                else psram_io_in_i[1] = cur.rdata[31 - k];
            end
        end
    end

    // Response monitor / scoreboard
    int   rsp_cnt = 0;
    logic prev_rsp = 1'b0;

    always @(negedge clk) begin
        txn_t e;
        if (!rst_i && rsp_valid_o) begin
            check("rsp_pulse", {31'h0, prev_rsp}, 32'h0);
            rsp_cnt++;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                check("rdata", rsp_rdata_o, e.wr ? 32'h0 : e.rdata);
                check("cmd", {24'h0, cmd_cap}, {24'h0, e.cmd});
                check("addr", {8'h0, addr_cap}, {8'h0, e.addr});
                if (e.wr) check("wdata", wd_cap, e.wdata);
                check("rises", rises, e.rises);
                check("io_en", en_bad, 0);
                check("sck_per", per, e.per);
                check("ce_end", {31'h0, psram_ce_o}, 32'h1);
            end
        end
        prev_rsp = rsp_valid_o;
    end

    int ce_hi = 0;
    int acc = 0;
    int gap = 0;
    int ce_falls = 0;

    always @(negedge clk) ce_hi = psram_ce_o ? ce_hi + 1 : 0;

    always @(posedge clk) begin
        if (!rst_i && req_valid_i && req_ready_o) begin
            acc++;
            gap = ce_hi;
        end
    end

    always @(negedge psram_ce_o) ce_falls++;

    task automatic drive(input txn_t t);
        pscr_i      = t.pscr;
        cmd_i       = t.cmd;
        wait_i      = t.wt;
        quad_i      = t.quad;
        req_wr_i    = t.wr;
        req_addr_i  = t.addr;
        req_wdata_i = t.wdata;
    endtask

    task automatic issue(input txn_t t, input bit hold);
        int i;
        @(negedge clk);
        sb.push_back(t);
        drive(t);
        req_valid_i = 1'b1;
        for (i = 0; i < 5000 && !req_ready_o; i++) @(negedge clk);
        if (i == 5000) check("issue_timeout", 32'h1, 32'h0);
        @(posedge clk);
        #1;
        if (!hold) req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 5000 && (sb.size() != 0 || !req_ready_o); i++)
            @(negedge clk);
        if (i == 5000) check("done_timeout", 32'h1, 32'h0);
    endtask

    initial begin
        txn_t t1;
        txn_t t2;
        int   a0;
        int   f0;
        int   r0;
        int   i;

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        drive(mk(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 24'd0, 32'd0, 32'd0));
        repeat (3) @(negedge clk);
        check("rst_ce", {31'h0, psram_ce_o}, 32'h1);
        check("rst_sck", {31'h0, psram_sck_o}, 32'h0);
        check("rst_io_en", {28'h0, psram_io_en_o}, 32'h0);
        check("rst_io_out", {28'h0, psram_io_out_o}, 32'h0);
        check("rst_ready", {31'h0, req_ready_o}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("rst_rdata", rsp_rdata_o, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        rst_i = 1'b0;

        // Reset during the data phase
        t1 = mk(1'b0, 1'b1, 8'd3, 8'hEB, 8'd2, 24'h0ABCDE, 32'h0, 32'h12345678);
        r0 = rsp_cnt;
        issue(t1, 1'b0);
        for (i = 0; i < 3000 && rises < 18; i++) @(negedge clk);
        check("mid_data_reached", {31'h0, rises >= 18}, 32'h1);
        rst_i = 1'b1;
        @(negedge clk);
        check("mr_ce", {31'h0, psram_ce_o}, 32'h1);
        check("mr_sck", {31'h0, psram_sck_o}, 32'h0);
        check("mr_io_en", {28'h0, psram_io_en_o}, 32'h0);
        check("mr_ready", {31'h0, req_ready_o}, 32'h1);
        check("mr_busy", {31'h0, busy_o}, 32'h0);
        check("mr_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (20) @(negedge clk);
        check("mr_no_rsp", rsp_cnt, r0);
        void'(sb.pop_front());

        // Quad read with dummy cycles
        issue(mk(1'b0, 1'b1, 8'd0, 8'hEB, 8'd6, 24'h123456, 32'h0,
                 32'hDEADBEEF), 1'b0);
        wait_done();

        // Single write, no dummy
        issue(mk(1'b1, 1'b0, 8'd3, 8'h02, 8'd5, 24'h000001, 32'hA5A5A5A5,
                 32'h0), 1'b0);
        wait_done();

        // Single read, wait=0
        issue(mk(1'b0, 1'b0, 8'd1, 8'h03, 8'd0, 24'hFFFFFF, 32'h0,
                 32'h00000001), 1'b0);
        wait_done();

        // Back-to-back with valid held and inputs changed mid-transfer
        t1 = mk(1'b0, 1'b1, 8'd1, 8'hEB, 8'd4, 24'h654321, 32'h0, 32'hCAFEF00D);
        t2 = mk(1'b0, 1'b0, 8'd1, 8'h03, 8'd0, 24'h800002, 32'h0, 32'h80000003);
        issue(t1, 1'b1);
        a0 = acc;
        sb.push_back(t2);
        drive(t2);
        for (i = 0; i < 5000 && acc == a0; i++) @(negedge clk);
        req_valid_i = 1'b0;
        check("b2b_accept", acc, a0 + 1);
        check("b2b_gap", {31'h0, gap >= 4}, 32'h1);
        wait_done();

        // Valid toggled while busy
        a0 = acc;
        f0 = ce_falls;
        issue(mk(1'b1, 1'b1, 8'd2, 8'h38, 8'd0, 24'h00F0F0, 32'h13579BDF,
                 32'h0), 1'b0);
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid_i = ~req_valid_i;
        end
        check("t6_busy", {31'h0, busy_o}, 32'h1);
        check("t6_ready", {31'h0, req_ready_o}, 32'h0);
        req_valid_i = 1'b0;
        wait_done();
        check("t6_accepts", acc, a0 + 1);
        check("t6_ce_falls", ce_falls, f0 + 1);
        check("t6_idle_busy", {31'h0, busy_o}, 32'h0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
